// File: rtl/johnson_phase_decoder.sv
// Johnson-code phase decoder with legality/sequence checking and a lock FSM.
// Optional sticky error flag and clear input when JOHNSON_DEC_STICKY_ERR_EN is defined.
module johnson_phase_decoder #(
  parameter int WIDTH    = 8,
  parameter int PH_W     = 4,
  parameter int LOCK_CNT = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [WIDTH-1:0]     q_in,
  input  logic                 q_valid,
`ifdef JOHNSON_DEC_STICKY_ERR_EN
  input  logic                 err_clr,
  output logic                 sticky_err,
`endif
  output logic [PH_W-1:0]      phase,
  output logic                 phase_valid,
  output logic [2*WIDTH-1:0]   phase_strobe,
  output logic                 illegal,
  output logic                 seq_err,
  output logic                 locked,
  output logic [7:0]           err_count
);

  localparam int NPH = 2 * WIDTH;

  typedef enum logic [1:0] {
    ST_UNLOCKED = 2'd0,
    ST_CHECKING = 2'd1,
    ST_LOCKED   = 2'd2
  } state_t;

  state_t             state_r, state_nx;
  logic [3:0]         match_r, match_nx;
  logic [PH_W-1:0]    prev_r, prev_nx, succ_s, dec_s, phase_r;
  logic [NPH-1:0]     strobe_r;
  logic               legal_s, take_s, illegal_s, seq_err_s, err_s;
  logic               phase_valid_r, illegal_r, seq_err_r, locked_r;
  logic [7:0]         err_count_r, cnt_nx;

  // A Johnson code has at most one boundary between its run of ones and zeros.
  function automatic logic is_legal(input logic [WIDTH-1:0] q);
    int unsigned n;
    n = 0;
    for (int i = 0; i < WIDTH - 1; i++) begin
      if (q[i] != q[i+1]) n++;
    end
    return (n <= 32'd1);
  endfunction

  function automatic logic [PH_W-1:0] decode(input logic [WIDTH-1:0] q);
    int unsigned ones;
    ones = 0;
    for (int i = 0; i < WIDTH; i++) begin
      if (q[i]) ones++;
    end
    if (q[WIDTH-1] == 1'b0) return PH_W'(ones);
    else                    return PH_W'(WIDTH + (WIDTH - int'(ones)));
  endfunction

  // Sample classification and expected successor
  always_comb begin
    legal_s = is_legal(q_in);
    dec_s   = decode(q_in);
    if (prev_r == PH_W'(NPH - 1)) succ_s = '0;
    else                          succ_s = prev_r + PH_W'(1);
  end

  // Lock FSM next-state, match counter and error pulses
  always_comb begin
    state_nx  = state_r;
    match_nx  = match_r;
    prev_nx   = prev_r;
    take_s    = 1'b0;
    illegal_s = 1'b0;
    seq_err_s = 1'b0;
    if (q_valid) begin
      if (!legal_s) begin
        illegal_s = 1'b1;
        state_nx  = ST_UNLOCKED;
        match_nx  = 4'd0;
      end else begin
        take_s  = 1'b1;
        prev_nx = dec_s;
        case (state_r)
          ST_UNLOCKED: begin
            match_nx = 4'd1;
            state_nx = (LOCK_CNT <= 1) ? ST_LOCKED : ST_CHECKING;
          end
          ST_CHECKING: begin
            if (dec_s == succ_s) match_nx = match_r + 4'd1;
            else                 match_nx = 4'd1;
            if (match_nx >= 4'(LOCK_CNT)) state_nx = ST_LOCKED;
            else                          state_nx = ST_CHECKING;
          end
          ST_LOCKED: begin
            if (dec_s == succ_s) begin
              state_nx = ST_LOCKED;
            end else begin
              seq_err_s = 1'b1;
              match_nx  = 4'd1;
              state_nx  = (LOCK_CNT <= 1) ? ST_LOCKED : ST_CHECKING;
            end
          end
          default: begin
            state_nx = ST_UNLOCKED;
            match_nx = 4'd0;
          end
        endcase
      end
    end else begin
      take_s = 1'b0;
    end
  end

  // Saturating error counter (clear has priority below a new error)
  always_comb begin
    err_s  = illegal_s | seq_err_s;
    cnt_nx = err_count_r;
    if (err_s && (err_count_r != 8'hFF)) cnt_nx = err_count_r + 8'd1;
    else                                 cnt_nx = err_count_r;
`ifdef JOHNSON_DEC_STICKY_ERR_EN
    if (err_clr) cnt_nx = err_s ? 8'd1 : 8'd0;
    else         cnt_nx = cnt_nx;
`endif
  end

  // State and registered outputs
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_r       <= ST_UNLOCKED;
      match_r       <= 4'd0;
      prev_r        <= '0;
      phase_r       <= '0;
      phase_valid_r <= 1'b0;
      strobe_r      <= '0;
      illegal_r     <= 1'b0;
      seq_err_r     <= 1'b0;
      locked_r      <= 1'b0;
      err_count_r   <= 8'd0;
    end else begin
      state_r       <= state_nx;
      match_r       <= match_nx;
      prev_r        <= prev_nx;
      phase_r       <= take_s ? dec_s : phase_r;
      phase_valid_r <= take_s;
      strobe_r      <= take_s ? (NPH'(1) << dec_s) : '0;
      illegal_r     <= illegal_s;
      seq_err_r     <= seq_err_s;
      locked_r      <= (state_nx == ST_LOCKED);
      err_count_r   <= cnt_nx;
    end
  end

`ifdef JOHNSON_DEC_STICKY_ERR_EN
  logic sticky_r;

  // Sticky error flag: a new error wins over a coincident clear
  always_ff @(posedge clk) begin
    if (!reset)                       sticky_r <= 1'b0;
    else if (illegal_s || seq_err_s)  sticky_r <= 1'b1;
    else if (err_clr)                 sticky_r <= 1'b0;
    else                              sticky_r <= sticky_r;
  end

  assign sticky_err = sticky_r;
`endif

  assign phase        = phase_r;
  assign phase_valid  = phase_valid_r;
  assign phase_strobe = strobe_r;
  assign illegal      = illegal_r;
  assign seq_err      = seq_err_r;
  assign locked       = locked_r;
  assign err_count    = err_count_r;

endmodule
